// File: rtl/apb_master_ctrl.sv
// APB4 requester: turns a valid/ready command stream into SETUP/ACCESS transfers
// and returns one registered response per command, with a PREADY watchdog.
module apb_master_ctrl #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                PCLK,
  input  logic                PRESET,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [DATA_W-1:0]   cmd_wdata,
  input  logic [DATA_W/8-1:0] cmd_strb,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic                rsp_timeout,
  output logic                PSEL,
  output logic                PENABLE,
  output logic                PWRITE,
  output logic [ADDR_W-1:0]   PADDR,
  output logic [DATA_W-1:0]   PWDATA,
  output logic [DATA_W/8-1:0] PSTRB,
  input  logic [DATA_W-1:0]   PRDATA,
  input  logic                PREADY,
  input  logic                PSLVERR
);

  // A zero TIMEOUT still needs a one-bit counter so the design elaborates.
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] CNT_LIMIT = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] wd_cnt;
  logic             accept;
  logic             complete;
  logic             abort;

  assign cmd_ready = (state == IDLE) || ((state == ACCESS) && PREADY);
  assign accept    = cmd_valid && cmd_ready;
  assign complete  = (state == ACCESS) && PREADY;
  assign abort     = (TIMEOUT != 0) && (state == ACCESS) && !PREADY && (wd_cnt == CNT_LIMIT);

  always_ff @(posedge PCLK) begin
    if (PRESET) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (cmd_valid) state_next = SETUP;
      SETUP:   state_next = ACCESS;
      ACCESS: begin
        if (complete)   state_next = cmd_valid ? SETUP : IDLE;
        else if (abort) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    PSEL    = (state != IDLE);
    PENABLE = (state == ACCESS);
  end

  // Request fields only change on acceptance, which keeps them stable for the whole transfer.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      PWRITE <= 1'b0;
      PADDR  <= '0;
      PWDATA <= '0;
      PSTRB  <= '0;
    end else if (accept) begin
      PWRITE <= cmd_write;
      PADDR  <= cmd_addr;
      PWDATA <= cmd_wdata;
      PSTRB  <= cmd_write ? cmd_strb : '0;
    end
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      wd_cnt <= '0;
    end else if (state == SETUP) begin
      wd_cnt <= '0;
    end else if ((state == ACCESS) && !PREADY && (wd_cnt != CNT_MAX)) begin
      wd_cnt <= wd_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      rsp_valid   <= complete || abort;
      rsp_rdata   <= (complete && !PWRITE) ? PRDATA : '0;
      rsp_err     <= complete ? PSLVERR : abort;
      rsp_timeout <= abort;
    end
  end

endmodule

// File: tb/tb_apb_master_ctrl.sv
// Directed bench for apb_master_ctrl: scoreboard of expected responses plus
// per-cycle checks of the APB handshake, with a TIMEOUT=0 side instance.
module tb_apb_master_ctrl;

  logic        PCLK = 1'b0;
  logic        PRESET;
  logic        cmd_valid, cmd_valid_z, cmd_write;
  logic [7:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_strb;
  logic [31:0] PRDATA;
  logic        PREADY, PSLVERR;

  logic        cmd_ready, rsp_valid, rsp_err, rsp_timeout;
  logic [31:0] rsp_rdata, PWDATA;
  logic        PSEL, PENABLE, PWRITE;
  logic [7:0]  PADDR;
  logic [3:0]  PSTRB;

  logic        cmd_ready_z, rsp_valid_z, rsp_err_z, rsp_timeout_z;
  logic [31:0] rsp_rdata_z, PWDATA_z;
  logic        PSEL_z, PENABLE_z, PWRITE_z;
  logic [7:0]  PADDR_z;
  logic [3:0]  PSTRB_z;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic        timeout;
  } rsp_t;

  rsp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  always #5 PCLK = ~PCLK;
  always @(posedge PCLK) cyc <= cyc + 1;

  apb_master_ctrl #(.ADDR_W(8), .DATA_W(32), .TIMEOUT(4)) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .PSTRB(PSTRB), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  apb_master_ctrl #(.ADDR_W(8), .DATA_W(32), .TIMEOUT(0)) dut_z (
    .PCLK(PCLK), .PRESET(PRESET),
    .cmd_valid(cmd_valid_z), .cmd_ready(cmd_ready_z), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
    .rsp_valid(rsp_valid_z), .rsp_rdata(rsp_rdata_z), .rsp_err(rsp_err_z), .rsp_timeout(rsp_timeout_z),
    .PSEL(PSEL_z), .PENABLE(PENABLE_z), .PWRITE(PWRITE_z), .PADDR(PADDR_z),
    .PWDATA(PWDATA_z), .PSTRB(PSTRB_z), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_rsp(input string tag);
    rsp_t e;
    check({tag, "_rsp_valid"}, rsp_valid, 1'b1);
    checks++;
    assert (exp_q.size() > 0) else begin
      errors++;
      $error("FAIL %s_sb observed=empty expected=entry", tag);
    end
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check({tag, "_rdata"},   rsp_rdata,   e.rdata);
      check({tag, "_err"},     rsp_err,     e.err);
      check({tag, "_timeout"}, rsp_timeout, e.timeout);
    end
  endtask

  // One isolated transfer; waits >= 4 means PREADY never rises and the watchdog fires.
  task automatic do_xfer(input string tag, input logic wr, input logic [7:0] addr,
                         input logic [31:0] wdata, input logic [3:0] strb,
                         input int waits, input logic slverr, input logic [31:0] rdata);
    rsp_t e;
    int   setup_cyc;
    int   n;
    logic to;
    logic rdy;
    to = (waits >= 4);
    e.rdata   = (wr || to) ? 32'h0 : rdata;
    e.err     = to ? 1'b1 : slverr;
    e.timeout = to;
    exp_q.push_back(e);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata; cmd_strb = strb;
    PREADY = 1'b0; PSLVERR = 1'b0;
    #1 check({tag, "_ready_idle"}, cmd_ready, 1'b1);
    @(negedge PCLK);
    setup_cyc = cyc;
    cmd_valid = 1'b0; cmd_addr = ~addr; cmd_wdata = ~wdata; cmd_strb = ~strb; cmd_write = ~wr;
    check({tag, "_setup_psel"},    PSEL, 1'b1);
    check({tag, "_setup_penable"}, PENABLE, 1'b0);
    check({tag, "_setup_paddr"},   PADDR, addr);
    check({tag, "_setup_pwrite"},  PWRITE, wr);
    check({tag, "_setup_pwdata"},  PWDATA, wdata);
    check({tag, "_setup_pstrb"},   PSTRB, wr ? strb : 4'h0);
    n = to ? 4 : waits + 1;
    for (int i = 0; i < n; i++) begin
      @(negedge PCLK);
      rdy = !to && (i == waits);
      if (rdy) begin
        PREADY = 1'b1; PSLVERR = slverr; PRDATA = rdata;
      end else begin
        PREADY = 1'b0; PSLVERR = 1'b1; PRDATA = $urandom;
      end
      #1;
      check({tag, "_acc_penable"}, PENABLE, 1'b1);
      check({tag, "_acc_paddr"},   PADDR, addr);
      check({tag, "_acc_pstrb"},   PSTRB, wr ? strb : 4'h0);
      check({tag, "_acc_ready"},   cmd_ready, rdy);
      check({tag, "_acc_no_rsp"},  rsp_valid, 1'b0);
    end
    @(negedge PCLK);
    PREADY = 1'b0; PSLVERR = 1'b0;
    check_rsp(tag);
    check({tag, "_latency"}, cyc - setup_cyc + 1, 3 + (to ? 3 : waits));
    check({tag, "_idle_psel"}, PSEL, 1'b0);
    @(negedge PCLK);
    check({tag, "_pulse_end"}, rsp_valid, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL sim_watchdog observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int pulses;
    PRESET = 1'b1; cmd_valid = 1'b0; cmd_valid_z = 1'b0; cmd_write = 1'b0;
    cmd_addr = '0; cmd_wdata = '0; cmd_strb = '0;
    PRDATA = '0; PREADY = 1'b0; PSLVERR = 1'b0;
    @(negedge PCLK); @(negedge PCLK);
    check("rst_psel", PSEL, 1'b0);
    check("rst_penable", PENABLE, 1'b0);
    check("rst_pwrite", PWRITE, 1'b0);
    check("rst_paddr", PADDR, 8'h0);
    check("rst_pwdata", PWDATA, 32'h0);
    check("rst_pstrb", PSTRB, 4'h0);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_rsp_err", rsp_err, 1'b0);
    check("rst_cmd_ready", cmd_ready, 1'b1);
    PRESET = 1'b0;
    @(negedge PCLK);

    do_xfer("wr_single", 1'b1, 8'h10, 32'hDEADBEEF, 4'hF, 0, 1'b0, 32'h0);
    do_xfer("rd_wait3",  1'b0, 8'h24, 32'h0BAD0BAD, 4'hF, 3, 1'b0, 32'h12345678);
    do_xfer("wr_slverr", 1'b1, 8'h5C, 32'hCAFEF00D, 4'h3, 2, 1'b1, 32'h0);
    do_xfer("rd_slverr_wait_only", 1'b0, 8'h60, 32'h0, 4'h0, 1, 1'b0, 32'h0000A5A5);
    do_xfer("rd_timeout", 1'b0, 8'h70, 32'h0, 4'h0, 100, 1'b0, 32'hFFFFFFFF);

    // Back-to-back reads with cmd_valid held high.
    PREADY = 1'b1; PSLVERR = 1'b0; PRDATA = 32'hA1A10001;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h30; cmd_strb = 4'hF;
    exp_q.push_back('{rdata: 32'hA1A10001, err: 1'b0, timeout: 1'b0});
    @(negedge PCLK);
    check("b2b_setup1_psel", PSEL, 1'b1);
    check("b2b_setup1_penable", PENABLE, 1'b0);
    check("b2b_setup1_paddr", PADDR, 8'h30);
    cmd_addr = 8'h34;
    exp_q.push_back('{rdata: 32'hB2B20002, err: 1'b0, timeout: 1'b0});
    #1 check("b2b_setup1_ready", cmd_ready, 1'b0);
    @(negedge PCLK);
    check("b2b_acc1_psel", PSEL, 1'b1);
    check("b2b_acc1_penable", PENABLE, 1'b1);
    check("b2b_acc1_ready", cmd_ready, 1'b1);
    @(negedge PCLK);
    check("b2b_setup2_psel", PSEL, 1'b1);
    check("b2b_setup2_penable", PENABLE, 1'b0);
    check("b2b_setup2_paddr", PADDR, 8'h34);
    check_rsp("b2b_1");
    cmd_valid = 1'b0; PRDATA = 32'hB2B20002;
    @(negedge PCLK);
    check("b2b_acc2_psel", PSEL, 1'b1);
    check("b2b_acc2_penable", PENABLE, 1'b1);
    check("b2b_gap", rsp_valid, 1'b0);
    @(negedge PCLK);
    check_rsp("b2b_2");
    check("b2b_idle_psel", PSEL, 1'b0);
    PREADY = 1'b0;
    @(negedge PCLK);
    check("b2b_pulse_end", rsp_valid, 1'b0);

    // Reset in the middle of ACCESS: transfer dropped, no response.
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h40;
    @(negedge PCLK);
    cmd_valid = 1'b0;
    @(negedge PCLK);
    check("rstmid_acc_penable", PENABLE, 1'b1);
    PRESET = 1'b1;
    @(negedge PCLK);
    check("rstmid_psel_next", PSEL, 1'b0);
    check("rstmid_penable_next", PENABLE, 1'b0);
    @(negedge PCLK);
    check("rstmid_psel", PSEL, 1'b0);
    check("rstmid_penable", PENABLE, 1'b0);
    check("rstmid_rsp_valid", rsp_valid, 1'b0);
    check("rstmid_cmd_ready", cmd_ready, 1'b1);
    PRESET = 1'b0; PREADY = 1'b1;
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge PCLK);
      if (rsp_valid) pulses++;
    end
    check("rstmid_no_rsp", pulses, 0);
    check("rstmid_sb_empty", exp_q.size(), 0);
    PREADY = 1'b0;

    // Watchdog disabled: a stuck slave never produces a response.
    cmd_valid_z = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h7E;
    @(negedge PCLK);
    cmd_valid_z = 1'b0;
    pulses = 0;
    for (int i = 0; i < 101; i++) begin
      @(negedge PCLK);
      if (rsp_valid_z) pulses++;
    end
    check("to0_no_rsp", pulses, 0);
    check("to0_psel", PSEL_z, 1'b1);
    check("to0_penable", PENABLE_z, 1'b1);
    check("to0_paddr", PADDR_z, 8'h7E);
    check("to0_main_idle", PSEL, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/apb_master_ctrl.md
Name: apb_master_ctrl

Overview:
- Parametrised APB4 requester that converts a valid/ready command stream into APB SETUP/ACCESS transfers and returns one registered response per command.
- Next-generation APB master for the peripheral subsystem. Adds over the basic IDLE/SETUP/ENABLE master:
  - configurable address/data width
  - byte strobes
  - PSLVERR capture
  - back-to-back transfers
  - a PREADY timeout watchdog

Parameters:
- ADDR_W, 8: PADDR / cmd_addr width (1..32).
- DATA_W, 32: PWDATA / PRDATA width; must be 8, 16 or 32.
- TIMEOUT, 16: maximum ACCESS cycles with PREADY low before the transfer is aborted; 0 disables the watchdog.

Ports:
- PCLK  in  1  clock; all logic on the rising edge.
- PRESET  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready at a PCLK edge.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_W  transfer address.
- cmd_wdata  in  DATA_W  write data.
- cmd_strb  in  DATA_W/8  write byte enables.
- rsp_valid  out  1  one-cycle response pulse; no backpressure.
- rsp_rdata  out  DATA_W  read data; 0 for writes and timeouts.
- rsp_err  out  1  PSLVERR sampled at completion, or timeout.
- rsp_timeout  out  1  transfer aborted by the watchdog.
- PSEL  out  1  APB select.
- PENABLE  out  1  APB enable.
- PWRITE  out  1  APB direction.
- PADDR  out  ADDR_W  APB address.
- PWDATA  out  DATA_W  APB write data.
- PSTRB  out  DATA_W/8  APB strobes; forced to 0 on reads.
- PRDATA  in  DATA_W  APB read data.
- PREADY  in  1  APB ready.
- PSLVERR  in  1  APB slave error.

Behaviour:
- **Reset.** PRESET sampled high at a PCLK edge → state IDLE. All outputs 0, watchdog counter 0. PRESET has priority over every other event.
  - Reset mid-transfer drops PSEL/PENABLE the next cycle.
  - No response is issued for the aborted transfer.
- **States.**
  - IDLE (PSEL=0, PENABLE=0).
  - SETUP (PSEL=1, PENABLE=0).
  - ACCESS (PSEL=1, PENABLE=1).
  - APB outputs are registered; there is no combinational path from cmd_* to P* outputs.
- **cmd_ready.** cmd_ready = (state==IDLE) || (state==ACCESS && PREADY). This is the only combinational input→output path.
- **IDLE.** cmd_valid → latch the command into PADDR/PWRITE/PWDATA/PSTRB and go to SETUP. Otherwise stay in IDLE.
- **SETUP.** Always → ACCESS. Clear the watchdog counter.
- **ACCESS, PREADY=1 (completion).**
  - Next cycle: rsp_valid=1, rsp_err=PSLVERR, rsp_timeout=0.
  - rsp_rdata = PRDATA for reads, 0 for writes.
  - If cmd_valid is high in the same cycle: latch the new command and go to SETUP (back-to-back). PSEL stays 1 and PENABLE drops to 0.
  - Otherwise go to IDLE.
- **ACCESS, PREADY=0.**
  - The watchdog counter increments.
  - TIMEOUT≠0 and the counter reaches TIMEOUT−1 while PREADY is still low → abort: go to IDLE; next cycle rsp_valid=1, rsp_err=1, rsp_timeout=1, rsp_rdata=0.
  - PREADY high on that same cycle wins: normal completion, no timeout.
- **Hold rule.** PADDR/PWRITE/PWDATA/PSTRB hold stable from SETUP through the end of ACCESS. In IDLE they hold their last values.
- **PSLVERR.** Sampled only on the completion cycle (PSEL && PENABLE && PREADY); ignored otherwise.
- **Latency.** Accepted at edge N → SETUP in cycle N+1, ACCESS in cycle N+2. With zero wait states, rsp_valid in cycle N+3. Each wait state adds one cycle.
- **Responses.** rsp_valid is high for exactly one cycle per accepted command; responses come in command order. Sustained throughput is one transfer per 2 cycles.
- **Counter width.** The watchdog counter is $clog2(TIMEOUT+1) bits and saturates; it never wraps.

Test Plan:
- **Reset.** PRESET=1 for 2 cycles mid-ACCESS → next cycle PSEL=0, PENABLE=0, rsp_valid=0, cmd_ready=1.
- **Single write.** addr=0x10, wdata=0xDEADBEEF, strb=0xF, PREADY=1 → SETUP then ACCESS with PADDR=0x10, PSTRB=0xF. rsp_valid in cycle N+3 with rsp_err=0, rsp_rdata=0.
- **Read with wait states.** Read addr=0x24, PREADY low 3 ACCESS cycles, then high with PRDATA=0x12345678 → PADDR stable throughout. rsp_rdata=0x12345678 in cycle N+6. PSTRB=0.
- **Back-to-back.** Two reads issued with cmd_valid held high → PSEL stays 1 across both transfers, PENABLE pattern 0,1,0,1. Two rsp_valid pulses 2 cycles apart.
- **Slave error.** Write with PSLVERR=1 on the completion cycle → rsp_err=1, rsp_timeout=0. PSLVERR=1 during wait cycles only → rsp_err=0.
- **Timeout.** TIMEOUT=4, PREADY held 0 → abort after 4 ACCESS cycles: rsp_err=1, rsp_timeout=1, rsp_rdata=0, state IDLE. Repeat with PREADY=1 on the 4th cycle → normal completion. TIMEOUT=0 with PREADY held low for 100 cycles → no response.
